// File: rtl/word_serial_tx.sv
// Framed single-wire transmitter: start bit, data LSB first, optional even parity, stop bit.
// Each serial bit is held for BIT_CYCLES clocks. A one-cycle done pulse follows every completed frame.
module word_serial_tx #(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_bus,
  output logic             in_ready,
  output logic             out_single,
  output logic             out_busy,
  output logic             out_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cyc_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             parity;
  logic             bit_end;

  assign bit_end  = (cyc_cnt == CW'(BIT_CYCLES - 1));
  assign in_ready = (state == S_IDLE) && !rst;
  assign out_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      out_done <= 1'b0;
      // Every non-idle state holds its bit for BIT_CYCLES clocks, then wraps the cycle counter.
      if (state != S_IDLE) begin
        cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shift_reg <= in_bus;
            parity    <= ^in_bus;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) state <= S_DATA;
        end
        S_DATA: begin
          if (bit_end) begin
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) state <= S_STOP;
        end
        S_STOP: begin
          if (bit_end) begin
            state    <= S_IDLE;
            out_done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_single = 1'b1;
    case (state)
      S_START:  out_single = 1'b0;
      S_DATA:   out_single = shift_reg[0];
      S_PARITY: out_single = parity;
      default:  out_single = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_word_serial_tx.sv
// Bench for word_serial_tx: a default-parameter instance plus a BIT_CYCLES=1, no-parity instance,
// checked cycle by cycle against a queue of expected line levels.
module tb_word_serial_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid2;
  logic [15:0] in_bus, in_bus2;
  logic        in_ready, out_single, out_busy, out_done;
  logic        in_ready2, out_single2, out_busy2, out_done2;

  int vectors = 0;
  int miscompares = 0;
  logic exp_q[$];

  localparam int F1 = (16 + 2 + 1) * 4;
  localparam int F2 = (16 + 2 + 0) * 1;

  always #5 clk = ~clk;

  word_serial_tx #(.WIDTH(16), .BIT_CYCLES(4), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bus(in_bus), .in_ready(in_ready),
    .out_single(out_single), .out_busy(out_busy), .out_done(out_done)
  );

  word_serial_tx #(.WIDTH(16), .BIT_CYCLES(1), .PARITY_EN(0)) dut_fast (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_bus(in_bus2), .in_ready(in_ready2),
    .out_single(out_single2), .out_busy(out_busy2), .out_done(out_done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for every clock of a frame, in transmission order.
  task automatic push_frame(input logic [15:0] w, input int bc, input bit par);
    logic [15:0] wv;
    wv = w;
    for (int c = 0; c < bc; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < bc; c++) exp_q.push_back(wv[i]);
    if (par)
      for (int c = 0; c < bc; c++) exp_q.push_back(^wv);
    for (int c = 0; c < bc; c++) exp_q.push_back(1'b1);
  endtask

  // Called right after the accepting edge; returns on the done cycle (or just after an abort).
  task automatic check_frame(input string name, input int glitch, input int abort_at);
    logic e;
    for (int n = 1; n <= F1; n++) begin
      e = (exp_q.size() == 0) ? 1'b1 : exp_q.pop_front();
      vectors++;
      if ({out_single, out_busy, out_done} !== {e, 2'b10}) begin
        miscompares++;
        $display("FAIL %s cycle %0d: line/busy/done=%b%b%b, expected %b10",
                 name, n, out_single, out_busy, out_done, e);
      end
      if (glitch != 0 && n == glitch) begin
        in_valid = 1'b1;
        in_bus   = 16'hFFFF;
      end
      if (glitch != 0 && n == glitch + 10) in_valid = 1'b0;
      if (glitch != 0 && in_valid) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL %s ready_while_busy cycle %0d: got %b, expected 0", name, n, in_ready);
        end
      end
      if (n == abort_at) begin
        rst = 1'b1;
        tick();
        vectors++;
        if ({out_single, out_busy, out_done, in_ready} !== 4'b1000) begin
          miscompares++;
          $display("FAIL %s abort: line/busy/done/ready=%b%b%b%b, expected 1000",
                   name, out_single, out_busy, out_done, in_ready);
        end
        exp_q.delete();
        rst = 1'b0;
        return;
      end
      tick();
    end
    vectors++;
    if ({out_single, out_busy, out_done} !== 3'b101) begin
      miscompares++;
      $display("FAIL %s done cycle %0d: line/busy/done=%b%b%b, expected 101",
               name, F1 + 1, out_single, out_busy, out_done);
    end
  endtask

  task automatic offer(input string name, input logic [15:0] w);
    in_valid = 1'b1;
    in_bus   = w;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before_accept: got %b, expected 1", name, in_ready);
    end
    push_frame(w, 4, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_bus = 16'h0;
    in_valid2 = 1'b0; in_bus2 = 16'h0;
    repeat (3) tick();
    vectors++;
    if ({out_single, in_ready, out_busy, out_done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_state: line/ready/busy/done=%b%b%b%b, expected 1000",
               out_single, in_ready, out_busy, out_done);
    end
    vectors++;
    if ({out_single2, in_ready2, out_busy2, out_done2} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_state_fast: line/ready/busy/done=%b%b%b%b, expected 1000",
               out_single2, in_ready2, out_busy2, out_done2);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_single_frame();
    offer("a5c3", 16'hA5C3);
    in_valid = 1'b0;
    check_frame("a5c3", 0, 0);
  endtask

  task automatic test_back_to_back();
    offer("b2b_first", 16'h0001);
    in_bus = 16'hFFFF;
    check_frame("b2b_first", 0, 0);
    offer("b2b_second", 16'hFFFF);
    in_valid = 1'b0;
    check_frame("b2b_second", 0, 0);
    tick();
    vectors++;
    if ({out_single, out_busy, out_done} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_after: line/busy/done=%b%b%b, expected 100", out_single, out_busy, out_done);
    end
  endtask

  task automatic test_ignore_while_busy();
    offer("ignore", 16'h1234);
    in_valid = 1'b0;
    check_frame("ignore", 10, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if ({out_single, out_busy, out_done} !== 3'b100) begin
        miscompares++;
        $display("FAIL ignore_no_second_frame %0d: line/busy/done=%b%b%b, expected 100",
                 k, out_single, out_busy, out_done);
      end
    end
    in_bus = 16'h0;
  endtask

  task automatic test_reset_mid_frame();
    offer("abort", 16'hC0DE);
    in_valid = 1'b0;
    check_frame("abort", 0, 21);
    for (int k = 0; k < F1; k++) begin
      tick();
      vectors++;
      if ({out_single, out_busy, out_done} !== 3'b100) begin
        miscompares++;
        $display("FAIL abort_quiet %0d: line/busy/done=%b%b%b, expected 100",
                 k, out_single, out_busy, out_done);
      end
    end
    offer("after_abort", 16'h5A3C);
    in_valid = 1'b0;
    check_frame("after_abort", 0, 0);
  endtask

  task automatic test_fast_no_parity();
    logic e;
    tick();
    in_valid2 = 1'b1;
    in_bus2   = 16'h8000;
    vectors++;
    if (in_ready2 !== 1'b1) begin
      miscompares++;
      $display("FAIL fast_ready: got %b, expected 1", in_ready2);
    end
    push_frame(16'h8000, 1, 1'b0);
    tick();
    in_valid2 = 1'b0;
    for (int n = 1; n <= F2; n++) begin
      e = (exp_q.size() == 0) ? 1'b1 : exp_q.pop_front();
      vectors++;
      if ({out_single2, out_busy2, out_done2} !== {e, 2'b10}) begin
        miscompares++;
        $display("FAIL fast cycle %0d: line/busy/done=%b%b%b, expected %b10",
                 n, out_single2, out_busy2, out_done2, e);
      end
      tick();
    end
    vectors++;
    if ({out_single2, out_busy2, out_done2} !== 3'b101) begin
      miscompares++;
      $display("FAIL fast done cycle %0d: line/busy/done=%b%b%b, expected 101",
               F2 + 1, out_single2, out_busy2, out_done2);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    tick();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_frame();
    tick();
    test_fast_no_parity();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
